// File: rtl/ntt_bank_arbiter_if.sv
// -----------------------------------------------------------------------------
// ntt_bank_arbiter_if
// Bundles the request/grant/memory signals of the NTT coefficient-bank
// arbiter. clk and rst are not part of the bundle.
//
// Handshake: every requester (host, butterfly read, butterfly write-back)
// raises its *_req with address (and host_we) stable for the cycle; a
// request is accepted in exactly the cycle its *_gnt is high. Grants are
// combinational, at most one is high per cycle, and there is no
// backpressure beyond an absent grant: an ungranted requester simply keeps
// *_req asserted.
//
// Modports
//   master : drives ntt_start/ntt_stop and the three requests, sees grants,
//            mem_*, mode, outstanding, err
//   slave  : the arbiter side (inverse directions)
// -----------------------------------------------------------------------------
interface ntt_bank_arbiter_if #(
   parameter int ADDR_W = 10,
   parameter int OUT_W  = 6
);
   logic              ntt_start;
   logic              ntt_stop;
   logic              host_req;
   logic              host_we;
   logic [ADDR_W-1:0] host_addr;
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic              wb_req;
   logic [ADDR_W-1:0] wb_addr;
   logic              host_gnt;
   logic              rd_gnt;
   logic              wb_gnt;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [1:0]        mode;
   logic [OUT_W-1:0]  outstanding;
   logic              err;

   modport master (
      output ntt_start, ntt_stop,
      output host_req, host_we, host_addr,
      output rd_req, rd_addr,
      output wb_req, wb_addr,
      input  host_gnt, rd_gnt, wb_gnt,
      input  mem_en, mem_we, mem_addr,
      input  mode, outstanding, err
   );

   modport slave (
      input  ntt_start, ntt_stop,
      input  host_req, host_we, host_addr,
      input  rd_req, rd_addr,
      input  wb_req, wb_addr,
      output host_gnt, rd_gnt, wb_gnt,
      output mem_en, mem_we, mem_addr,
      output mode, outstanding, err
   );
endinterface

// File: rtl/ntt_bank_arbiter.sv
// -----------------------------------------------------------------------------
// ntt_bank_arbiter
// Arbitrates one single-port coefficient bank between the host (load/unload)
// and the NTT butterfly datapath (operand reads, result write-backs).
//
// Ports
//   clk  : clock, all state on the rising edge
//   rst  : asynchronous, active-high reset
//   bus  : ntt_bank_arbiter_if.slave
//          ntt_start/ntt_stop  ownership transfer pulses
//          host_*/rd_*/wb_*    requests; *_gnt one-hot-or-zero grants
//          mem_en/we/addr      bank port, copy of the granted requester
//          mode                0 HOST_MODE, 1 NTT_MODE, 2 DRAIN (FSM state)
//          outstanding         reads granted minus write-backs granted
//          err                 sticky protocol error
//
// Optional feature: define NTT_ARB_STARVE_GUARD_EN to add a read-starvation
// guard in NTT_MODE. After STARVE_LIM consecutive cycles of an ungranted
// rd_req, the next cycle gives the slot to the read instead of a write-back.
// Without the macro, write-back always wins and no counter exists.
// -----------------------------------------------------------------------------
module ntt_bank_arbiter #(
   parameter int ADDR_W     = 10,
   parameter int OUT_W      = 6,
   parameter int STARVE_LIM = 8
) (
   input logic               clk,
   input logic               rst,
   ntt_bank_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      HOST_MODE = 2'd0,
      NTT_MODE  = 2'd1,
      DRAIN     = 2'd2
   } mode_t;

   localparam logic [OUT_W-1:0] OUT_MAX = '1;

   mode_t             mode_q, mode_d;
   logic [OUT_W-1:0]  out_q, out_d;
   logic              err_q, err_d;
   logic              host_gnt, rd_gnt, wb_gnt;
   logic              rd_ok;
   logic              starve_force;
   logic              mem_en, mem_we;
   logic [ADDR_W-1:0] mem_addr;

`ifdef NTT_ARB_STARVE_GUARD_EN
   localparam int SC_W = $clog2(STARVE_LIM + 1);
   localparam logic [SC_W-1:0] LIM = SC_W'(STARVE_LIM);

   logic [SC_W-1:0] starve_q, starve_d;

   assign starve_force = (starve_q == LIM);

   // Counts only consecutive starved NTT_MODE cycles; any break clears it.
   // Holds at LIM if the read still cannot go (outstanding saturated).
   always_comb begin
      starve_d = '0;
      if (mode_q == NTT_MODE && bus.rd_req && !rd_gnt)
         starve_d = (starve_q == LIM) ? LIM : starve_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) starve_q <= '0;
      else     starve_q <= starve_d;
   end
`else
   assign starve_force = 1'b0;
`endif

   // Grant selection. Gated by rst so nothing reaches the bank while reset
   // is asserted, even though the grant path is purely combinational.
   always_comb begin
      host_gnt = 1'b0;
      rd_gnt   = 1'b0;
      wb_gnt   = 1'b0;
      rd_ok    = bus.rd_req && (out_q != OUT_MAX);
      if (!rst) begin
         unique case (mode_q)
            HOST_MODE: host_gnt = bus.host_req;
            NTT_MODE: begin
               if (starve_force && rd_ok) rd_gnt = 1'b1;
               else if (bus.wb_req)       wb_gnt = 1'b1;
               else if (rd_ok)            rd_gnt = 1'b1;
            end
            DRAIN:     wb_gnt = bus.wb_req;
            default:   ;
         endcase
      end
   end

   // Bank port follows the granted requester; idle port is all zero.
   always_comb begin
      mem_en   = host_gnt | rd_gnt | wb_gnt;
      mem_we   = 1'b0;
      mem_addr = '0;
      if (host_gnt) begin
         mem_we   = bus.host_we;
         mem_addr = bus.host_addr;
      end else if (rd_gnt) begin
         mem_addr = bus.rd_addr;
      end else if (wb_gnt) begin
         mem_we   = 1'b1;
         mem_addr = bus.wb_addr;
      end
   end

   // Next-state: mode FSM, outstanding counter, sticky error.
   always_comb begin
      mode_d = mode_q;
      out_d  = out_q;
      err_d  = err_q;

      // A write-back with nothing outstanding is a protocol error; the
      // counter holds at zero rather than wrapping.
      if (rd_gnt) begin
         out_d = out_q + 1'b1;
      end else if (wb_gnt) begin
         if (out_q == '0) err_d = 1'b1;
         else             out_d = out_q - 1'b1;
      end

      if (bus.ntt_start && mode_q != HOST_MODE) err_d = 1'b1;

      // ntt_stop is only looked at in NTT_MODE, where it also overrides a
      // simultaneous ntt_start. DRAIN leaves once the registered count
      // is zero, i.e. the cycle after the last write-back lands.
      unique case (mode_q)
         HOST_MODE: if (bus.ntt_start) mode_d = NTT_MODE;
         NTT_MODE:  if (bus.ntt_stop)  mode_d = DRAIN;
         DRAIN:     if (out_q == '0)   mode_d = HOST_MODE;
         default:   mode_d = HOST_MODE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q <= HOST_MODE;
         out_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         mode_q <= mode_d;
         out_q  <= out_d;
         err_q  <= err_d;
      end
   end

   assign bus.host_gnt    = host_gnt;
   assign bus.rd_gnt      = rd_gnt;
   assign bus.wb_gnt      = wb_gnt;
   assign bus.mem_en      = mem_en;
   assign bus.mem_we      = mem_we;
   assign bus.mem_addr    = mem_addr;
   assign bus.mode        = mode_q;
   assign bus.outstanding = out_q;
   assign bus.err         = err_q;

endmodule

// File: tb/tb_ntt_bank_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ntt_bank_arbiter
// Directed and randomized bench for ntt_bank_arbiter. A behavioural model
// (integers for mode/outstanding/starvation, a bit for err) predicts every
// grant and bank-port value; a second instance with OUT_W=2 covers counter
// saturation. Honours NTT_ARB_STARVE_GUARD_EN when defined.
// -----------------------------------------------------------------------------
module tb_ntt_bank_arbiter;

   localparam int ADDR_W     = 10;
   localparam int OUT_W      = 6;
   localparam int STARVE_LIM = 8;
   localparam int OUT_MAX    = (1 << OUT_W) - 1;
`ifdef NTT_ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ntt_bank_arbiter_if #(.ADDR_W(ADDR_W), .OUT_W(OUT_W)) bus ();
   ntt_bank_arbiter_if #(.ADDR_W(ADDR_W), .OUT_W(2))     bus2 ();

   ntt_bank_arbiter #(.ADDR_W(ADDR_W), .OUT_W(OUT_W), .STARVE_LIM(STARVE_LIM)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );
   ntt_bank_arbiter #(.ADDR_W(ADDR_W), .OUT_W(2), .STARVE_LIM(STARVE_LIM)) dut2 (
      .clk(clk), .rst(rst), .bus(bus2)
   );

   int checks = 0;
   int errors = 0;

   // reference model state
   int m_mode, m_out, m_starve;
   bit m_err;
   // predicted combinational outputs for the current cycle
   bit e_h, e_r, e_w, e_we;
   logic [ADDR_W-1:0] e_addr;
   // last observed grants (for pattern tracking)
   bit last_rd, last_wb;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drv(input bit start, input bit stop, input bit hreq, input bit hwe,
                      input int haddr, input bit rreq, input int raddr,
                      input bit wreq, input int waddr);
      bus.ntt_start = start;
      bus.ntt_stop  = stop;
      bus.host_req  = hreq;
      bus.host_we   = hwe;
      bus.host_addr = ADDR_W'(haddr);
      bus.rd_req    = rreq;
      bus.rd_addr   = ADDR_W'(raddr);
      bus.wb_req    = wreq;
      bus.wb_addr   = ADDR_W'(waddr);
   endtask

   task automatic idle2();
      bus2.ntt_start = 0; bus2.ntt_stop = 0; bus2.host_req = 0; bus2.host_we = 0;
      bus2.host_addr = '0; bus2.rd_req = 0; bus2.rd_addr = '0; bus2.wb_req = 0;
      bus2.wb_addr = '0;
   endtask

   // Model: who owns the bank this cycle and who wins.
   task automatic predict();
      bit rd_ok, force_rd;
      e_h = 0; e_r = 0; e_w = 0; e_we = 0; e_addr = '0;
      rd_ok    = bus.rd_req && (m_out < OUT_MAX);
      force_rd = GUARD && (m_starve >= STARVE_LIM);
      case (m_mode)
         0: e_h = bus.host_req;
         1: begin
            if (force_rd && rd_ok) e_r = 1;
            else if (bus.wb_req)   e_w = 1;
            else                   e_r = rd_ok;
         end
         default: e_w = bus.wb_req;
      endcase
      if (e_h) begin e_we = bus.host_we; e_addr = bus.host_addr; end
      if (e_r) e_addr = bus.rd_addr;
      if (e_w) begin e_we = 1; e_addr = bus.wb_addr; end
   endtask

   task automatic model_step();
      int nm;
      nm = m_mode;
      if (m_mode == 0 && bus.ntt_start) nm = 1;
      if (m_mode == 1 && bus.ntt_stop)  nm = 2;
      if (m_mode == 2 && m_out == 0)    nm = 0;
      if (bus.ntt_start && m_mode != 0) m_err = 1;
      if (e_w && m_out == 0)            m_err = 1;
      if (m_mode == 1 && bus.rd_req && !e_r)
         m_starve = (m_starve < STARVE_LIM) ? m_starve + 1 : STARVE_LIM;
      else
         m_starve = 0;
      m_out  = m_out + (e_r ? 1 : 0) - ((e_w && m_out > 0) ? 1 : 0);
      m_mode = nm;
   endtask

   // One clock cycle: inputs already driven at the negedge.
   task automatic cycle();
      predict();
      #1;
      chk("host_gnt", bus.host_gnt, e_h);
      chk("rd_gnt", bus.rd_gnt, e_r);
      chk("wb_gnt", bus.wb_gnt, e_w);
      chk("mem_en", bus.mem_en, e_h | e_r | e_w);
      chk("mem_we", bus.mem_we, e_we);
      chk("mem_addr", bus.mem_addr, e_addr);
      chk("mode", bus.mode, m_mode);
      chk("outstanding", bus.outstanding, m_out);
      chk("err", bus.err, m_err);
      last_rd = bus.rd_gnt;
      last_wb = bus.wb_gnt;
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      drv(0, 0, 1, 1, 3, 1, 4, 1, 6);
      idle2();
      rst = 1'b1;
      #1;
      chk("rst_mode", bus.mode, 0);
      chk("rst_out", bus.outstanding, 0);
      chk("rst_err", bus.err, 0);
      chk("rst_gnts", {bus.host_gnt, bus.rd_gnt, bus.wb_gnt}, 0);
      chk("rst_mem", {bus.mem_en, bus.mem_we, bus.mem_addr}, 0);
      @(negedge clk);
      @(negedge clk);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      m_mode = 0; m_out = 0; m_starve = 0; m_err = 0;
   endtask

   initial begin
      int first_rd, rd_cnt, wb_cnt;

      // reset, then a host write in the same cycle
      do_reset();
      drv(0, 0, 1, 1, 5, 0, 0, 0, 0);
      #1;
      chk("host_wr_gnt", bus.host_gnt, 1);
      chk("host_wr_mem", {bus.mem_en, bus.mem_we, bus.mem_addr}, {2'b11, 10'd5});
      chk("host_wr_mode", bus.mode, 0);
      cycle();

      // start with a concurrent host access, 3 reads, stop, 3 write-backs
      drv(1, 0, 1, 0, 9, 1, 1, 0, 0);
      cycle();
      chk("ntt_mode", bus.mode, 1);
      for (int i = 0; i < 3; i++) begin
         drv(0, 0, 1, 0, 0, 1, 16 + i, 0, 0);
         cycle();
      end
      chk("out_three", bus.outstanding, 3);
      drv(0, 1, 0, 0, 0, 0, 0, 0, 0);
      cycle();
      chk("drain_mode", bus.mode, 2);
      for (int i = 0; i < 3; i++) begin
         drv(1, 0, 0, 0, 0, 1, 2, 1, 32 + i);   // start in DRAIN is an error
         cycle();
      end
      chk("drain_out0", bus.outstanding, 0);
      chk("drain_still", bus.mode, 2);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle();
      chk("back_host", bus.mode, 0);
      chk("start_in_drain_err", bus.err, 1);

      // write-back with nothing outstanding
      do_reset();
      drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle();
      drv(0, 0, 0, 0, 0, 0, 0, 1, 7);
      cycle();
      chk("wb_underflow_err", bus.err, 1);
      chk("wb_underflow_out", bus.outstanding, 0);
      for (int i = 0; i < 4; i++) begin
         drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
         cycle();
      end
      chk("err_sticky", bus.err, 1);

      // start+stop together in NTT_MODE: stop wins, start flags err
      do_reset();
      drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle();
      drv(1, 1, 0, 0, 0, 0, 0, 0, 0);
      cycle();
      chk("stop_wins_mode", bus.mode, 2);
      chk("stop_wins_err", bus.err, 1);
      drv(0, 1, 0, 0, 0, 0, 0, 0, 0);   // stop ignored in DRAIN
      cycle();
      chk("drain_empty_exit", bus.mode, 0);

      // rd and wb both held: write-back priority, optional starvation slot
      do_reset();
      drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle();
      first_rd = 0; rd_cnt = 0; wb_cnt = 0;
      for (int i = 1; i <= 12; i++) begin
         drv(0, 0, 0, 0, 0, 1, 100 + i, 1, 200 + i);
         cycle();
         if (last_rd) begin
            rd_cnt++;
            if (first_rd == 0) first_rd = i;
         end
         if (last_wb) wb_cnt++;
      end
      chk("starve_first_rd", first_rd, GUARD ? 9 : 0);
      chk("starve_rd_cnt", rd_cnt, GUARD ? 1 : 0);
      chk("starve_wb_cnt", wb_cnt, GUARD ? 11 : 12);

      // randomized traffic against the model
      do_reset();
      for (int i = 0; i < 600; i++) begin
         drv($urandom_range(0, 15) == 0, $urandom_range(0, 24) == 0,
             $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
             int'($urandom_range(0, 1023)),
             $urandom_range(0, 9) < 6, int'($urandom_range(0, 1023)),
             $urandom_range(0, 9) < 4, int'($urandom_range(0, 1023)));
         cycle();
      end

      // asynchronous reset mid-DRAIN with butterflies in flight
      do_reset();
      drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle();
      for (int i = 0; i < 2; i++) begin
         drv(0, 0, 0, 0, 0, 1, 40 + i, 0, 0);
         cycle();
      end
      drv(0, 1, 0, 0, 0, 0, 0, 0, 0);
      cycle();
      chk("pre_rst_mode", bus.mode, 2);
      chk("pre_rst_out", bus.outstanding, 2);
      drv(0, 0, 0, 0, 0, 0, 0, 1, 50);
      #1;
      chk("pre_rst_wb", bus.wb_gnt, 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_mode", bus.mode, 0);
      chk("mid_rst_out", bus.outstanding, 0);
      chk("mid_rst_gnts", {bus.host_gnt, bus.rd_gnt, bus.wb_gnt, bus.mem_en}, 0);
      @(negedge clk);
      do_reset();

      // OUT_W=2 instance: saturation at 3 blocks further reads
      bus2.ntt_start = 1;
      @(negedge clk);
      bus2.ntt_start = 0;
      bus2.rd_req = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("sat_rd_gnt", bus2.rd_gnt, 1);
         @(negedge clk);
      end
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("sat_blocked", bus2.rd_gnt, 0);
         chk("sat_out", bus2.outstanding, 3);
         chk("sat_mem_en", bus2.mem_en, 0);
         @(negedge clk);
      end
      idle2();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
